// File: rtl/eeg_wram_mst_pkg.sv
// rtl/eeg_wram_mst_pkg.sv - shared state encoding and command mode constants for eeg_wram_mst
package eeg_wram_mst_pkg;

    // One-hot transfer state
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WR   = 3'b010,
        ST_RD   = 3'b100
    } state_e;

    localparam logic MODE_WR = 1'b0;
    localparam logic MODE_RD = 1'b1;

endpackage

// File: rtl/eeg_wram_mst_fifo.sv
// rtl/eeg_wram_mst_fifo.sv - synchronous read-return FIFO with registered head
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes pointers and count)
//   push_i, din_i   write side; a push while full is dropped
//   pop_i, dout_o   read side; dout_o is the registered head entry
//   full_o, empty_o status flags
//   count_o         current occupancy, 0..DEPTH
module eeg_wram_mst_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/eeg_wram_mst.sv
// rtl/eeg_wram_mst.sv - engine-side access master for one WRAM bank (block write / block read)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   is_idle_o                FSM is in IDLE
//   cmd_*                    block command (mode, base address, beats minus one)
//   src_dat_*                write source stream, passed straight to the bank in WR
//   etow_dat_*               addressed write beats to the bank
//   etow_add_*               addressed read requests to the bank
//   wtoe_dat_*               read data returned by the bank (never back-pressured)
//   snk_dat_*                read data sink stream, fed from the return FIFO
//   err_o                    sticky protocol error on the return path
module eeg_wram_mst
    import eeg_wram_mst_pkg::*;
#(
    parameter int ADD_AW     = 13,
    parameter int DAT_DW     = 8,
    parameter int LEN_DW     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              is_idle_o,
    input  logic              cmd_vld_i,
    output logic              cmd_rdy_o,
    input  logic              cmd_mode_i,
    input  logic [ADD_AW-1:0] cmd_base_i,
    input  logic [LEN_DW-1:0] cmd_len_i,
    input  logic              src_dat_vld_i,
    output logic              src_dat_rdy_o,
    input  logic [DAT_DW-1:0] src_dat_dat_i,
    output logic              etow_dat_vld_o,
    output logic              etow_dat_lst_o,
    input  logic              etow_dat_rdy_i,
    output logic [ADD_AW-1:0] etow_dat_add_o,
    output logic [DAT_DW-1:0] etow_dat_dat_o,
    output logic              etow_add_vld_o,
    output logic              etow_add_lst_o,
    input  logic              etow_add_rdy_i,
    output logic [ADD_AW-1:0] etow_add_add_o,
    input  logic              wtoe_dat_vld_i,
    input  logic              wtoe_dat_lst_i,
    output logic              wtoe_dat_rdy_o,
    input  logic [DAT_DW-1:0] wtoe_dat_dat_i,
    output logic              snk_dat_vld_o,
    output logic              snk_dat_lst_o,
    input  logic              snk_dat_rdy_i,
    output logic [DAT_DW-1:0] snk_dat_dat_o,
    output logic              err_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q;
    logic [ADD_AW-1:0] addr_q;       // next address to issue (write or read)
    logic [LEN_DW-1:0] beat_q;       // address-side beats remaining minus one
    logic              addr_done_q;  // RD: final read address already issued
    logic [LEN_DW-1:0] ret_q;        // RD: bank returns remaining minus one
    logic [LEN_DW-1:0] snk_q;        // RD: sink beats remaining minus one
    logic [CW-1:0]     outst_q;      // reads issued but not yet returned
    logic [CW-1:0]     outst_d;
    logic              err_q;

    logic              in_wr;
    logic              in_rd;
    logic              cmd_acc;
    logic              wr_acc;
    logic              add_vld;
    logic              add_acc;
    logic              outst_dec;
    logic              err_set;
    logic              snk_vld;
    logic              snk_pop;
    logic [CW:0]       used;

    logic              fifo_clr;
    logic              fifo_push;
    logic [DAT_DW-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;

    assign in_wr   = (state_q == ST_WR);
    assign in_rd   = (state_q == ST_RD);
    assign cmd_acc = (state_q == ST_IDLE) & cmd_vld_i;
    assign wr_acc  = in_wr & src_dat_vld_i & etow_dat_rdy_i;

    // Credit: never have more reads in flight plus buffered than the FIFO can hold,
    // so the never-back-pressured return path cannot overflow.
    assign used    = {1'b0, outst_q} + {1'b0, fifo_cnt};
    assign add_vld = in_rd & ~addr_done_q & (used < (CW + 1)'(FIFO_DEPTH));
    assign add_acc = add_vld & etow_add_rdy_i;

    // A stray return with nothing outstanding must not wrap the counter.
    assign outst_dec = wtoe_dat_vld_i & (outst_q != '0);

    always_comb begin
        outst_d = outst_q;
        case ({add_acc, outst_dec})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    assign err_set = wtoe_dat_vld_i &
                     ((outst_q == '0) | (wtoe_dat_lst_i != (ret_q == '0)));

    assign snk_vld = in_rd & ~fifo_empty;
    assign snk_pop = snk_vld & snk_dat_rdy_i;

    // Flushing on accept keeps stray returns seen in IDLE out of the next read.
    assign fifo_clr  = rst | cmd_acc;
    assign fifo_push = wtoe_dat_vld_i & ~fifo_full;

    eeg_wram_mst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DAT_DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (fifo_clr),
        .push_i  (fifo_push),
        .din_i   (wtoe_dat_dat_i),
        .pop_i   (snk_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            addr_done_q <= 1'b0;
            ret_q       <= '0;
            snk_q       <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            outst_q <= outst_d;
            err_q   <= cmd_acc ? err_set : (err_q | err_set);
            case (state_q)
                ST_IDLE: begin
                    if (cmd_vld_i) begin
                        addr_q      <= cmd_base_i;
                        beat_q      <= cmd_len_i;
                        ret_q       <= cmd_len_i;
                        snk_q       <= cmd_len_i;
                        addr_done_q <= 1'b0;
                        state_q     <= (cmd_mode_i == MODE_RD) ? ST_RD : ST_WR;
                    end
                end
                ST_WR: begin
                    if (wr_acc) begin
                        addr_q <= addr_q + 1'b1;
                        beat_q <= beat_q - 1'b1;
                        if (beat_q == '0) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_RD: begin
                    if (add_acc) begin
                        addr_q <= addr_q + 1'b1;
                        if (beat_q == '0) begin
                            addr_done_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q - 1'b1;
                        end
                    end
                    if (wtoe_dat_vld_i && (ret_q != '0)) begin
                        ret_q <= ret_q - 1'b1;
                    end
                    if (snk_pop) begin
                        if (snk_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            snk_q <= snk_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign is_idle_o      = (state_q == ST_IDLE);
    assign cmd_rdy_o      = is_idle_o;
    assign wtoe_dat_rdy_o = 1'b1;

    assign src_dat_rdy_o  = in_wr & etow_dat_rdy_i;
    assign etow_dat_vld_o = in_wr & src_dat_vld_i;
    assign etow_dat_lst_o = in_wr & (beat_q == '0);
    assign etow_dat_add_o = in_wr ? addr_q : '0;
    assign etow_dat_dat_o = in_wr ? src_dat_dat_i : '0;

    assign etow_add_vld_o = add_vld;
    assign etow_add_lst_o = in_rd & ~addr_done_q & (beat_q == '0);
    assign etow_add_add_o = in_rd ? addr_q : '0;

    assign snk_dat_vld_o  = snk_vld;
    assign snk_dat_lst_o  = snk_vld & (snk_q == '0);
    assign snk_dat_dat_o  = snk_vld ? fifo_head : '0;

    assign err_o          = err_q;

endmodule

// File: tb/tb_eeg_wram_mst.sv
// tb/tb_eeg_wram_mst.sv - self-checking bench for eeg_wram_mst
module tb_eeg_wram_mst;

    localparam int AMOD = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_mode = 1'b0;
    logic [12:0] cmd_base = '0;
    logic [12:0] cmd_len = '0;
    logic        src_vld = 1'b0;
    logic [7:0]  src_dat = '0;
    logic        etow_dat_rdy = 1'b0;
    logic        etow_add_rdy = 1'b0;
    logic        wtoe_vld = 1'b0;
    logic        wtoe_lst = 1'b0;
    logic [7:0]  wtoe_dat = '0;
    logic        snk_rdy = 1'b0;

    logic        is_idle, cmd_rdy, src_rdy;
    logic        etow_dat_vld, etow_dat_lst, etow_add_vld, etow_add_lst;
    logic [12:0] etow_dat_add, etow_add_add;
    logic [7:0]  etow_dat_dat, snk_dat;
    logic        wtoe_rdy, snk_vld, snk_lst, err;

    eeg_wram_mst dut (
        .clk(clk), .rst(rst), .is_idle_o(is_idle),
        .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy), .cmd_mode_i(cmd_mode),
        .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
        .src_dat_vld_i(src_vld), .src_dat_rdy_o(src_rdy), .src_dat_dat_i(src_dat),
        .etow_dat_vld_o(etow_dat_vld), .etow_dat_lst_o(etow_dat_lst),
        .etow_dat_rdy_i(etow_dat_rdy), .etow_dat_add_o(etow_dat_add),
        .etow_dat_dat_o(etow_dat_dat),
        .etow_add_vld_o(etow_add_vld), .etow_add_lst_o(etow_add_lst),
        .etow_add_rdy_i(etow_add_rdy), .etow_add_add_o(etow_add_add),
        .wtoe_dat_vld_i(wtoe_vld), .wtoe_dat_lst_i(wtoe_lst),
        .wtoe_dat_rdy_o(wtoe_rdy), .wtoe_dat_dat_i(wtoe_dat),
        .snk_dat_vld_o(snk_vld), .snk_dat_lst_o(snk_lst),
        .snk_dat_rdy_i(snk_rdy), .snk_dat_dat_o(snk_dat),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Environment state: bank memory, source queue, observed beat logs
    logic [7:0] bank_mem [AMOD];
    int  src_q[$];
    int  exp_w[$];
    int  wq_add[$], wq_dat[$], wq_lst[$], wq_cyc[$];
    int  aq_add[$], aq_lst[$], aq_cyc[$];
    int  sq_dat[$], sq_lst[$], sq_cyc[$];
    int  cyc = 0;
    int  cmd_acc_cnt = 0;
    int  cmd_acc_cyc = 0;
    int  idle_cyc = 0;
    bit  prev_idle = 1'b1;
    bit  pend = 1'b0;
    int  pa = 0;
    bit  pl = 1'b0;
    bit  src_take = 1'b0;
    bit  inject = 1'b0;
    logic [7:0] inj_dat = '0;
    bit  rnd = 1'b0;
    bit  snk_hold = 1'b0;

    // Bank, source and sink models: observe at negedge, drive 1 time unit after posedge.
    // The bank answers each accepted read address exactly one cycle later.
    always begin
        @(negedge clk);
        cyc++;
        pend = 1'b0;
        src_take = 1'b0;
        if (!rst) begin
            if (etow_dat_vld && etow_dat_rdy) begin
                wq_add.push_back(int'(etow_dat_add));
                wq_dat.push_back(int'(etow_dat_dat));
                wq_lst.push_back(int'(etow_dat_lst));
                wq_cyc.push_back(cyc);
            end
            if (etow_add_vld && etow_add_rdy) begin
                aq_add.push_back(int'(etow_add_add));
                aq_lst.push_back(int'(etow_add_lst));
                aq_cyc.push_back(cyc);
                pend = 1'b1;
                pa = int'(etow_add_add);
                pl = etow_add_lst;
            end
            if (snk_vld && snk_rdy) begin
                sq_dat.push_back(int'(snk_dat));
                sq_lst.push_back(int'(snk_lst));
                sq_cyc.push_back(cyc);
            end
            if (cmd_vld && cmd_rdy) begin
                cmd_acc_cnt++;
                cmd_acc_cyc = cyc;
            end
            src_take = src_vld && src_rdy;
        end
        if (is_idle && !prev_idle) idle_cyc = cyc;
        prev_idle = is_idle;
        @(posedge clk);
        #1;
        if (src_take && src_q.size() > 0) void'(src_q.pop_front());
        src_vld = (src_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
        src_dat = (src_q.size() > 0) ? 8'(src_q[0]) : 8'h00;
        wtoe_vld = pend || inject;
        wtoe_dat = pend ? bank_mem[pa] : inj_dat;
        wtoe_lst = pend ? pl : 1'b0;
        etow_dat_rdy = !rnd || ($urandom_range(0, 3) != 0);
        etow_add_rdy = !rnd || ($urandom_range(0, 3) != 0);
        snk_rdy = !snk_hold && (!rnd || ($urandom_range(0, 2) != 0));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_logs();
        wq_add.delete(); wq_dat.delete(); wq_lst.delete(); wq_cyc.delete();
        aq_add.delete(); aq_lst.delete(); aq_cyc.delete();
        sq_dat.delete(); sq_lst.delete(); sq_cyc.delete();
        exp_w.delete();
    endtask

    task automatic fill_src(input int n);
        for (int i = 0; i < n; i++) begin
            int d;
            d = int'($urandom_range(0, 255));
            src_q.push_back(d);
            exp_w.push_back(d);
        end
    endtask

    task automatic issue(input bit mode, input int base, input int len);
        bit got;
        got = 1'b0;
        cmd_vld = 1'b1;
        cmd_mode = mode;
        cmd_base = 13'(base);
        cmd_len = 13'(len);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = cmd_rdy;
            tick();
        end
        cmd_vld = 1'b0;
        if (!got) chk("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = is_idle;
        end
        if (!seen) chk({tag, ".idle_timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    // Reference: beat i of a transfer targets (base+i) mod 2^13, LST only on i == len,
    // read data is the bank contents at that address.
    task automatic check_xfer(input bit mode, input int base, input int len, input string tag);
        if (mode == 1'b0) begin
            chk({tag, ".wbeats"}, 32'(wq_add.size()), 32'(len + 1));
            for (int i = 0; i <= len && i < wq_add.size(); i++) begin
                chk($sformatf("%s.wadd%0d", tag, i), 32'(wq_add[i]), 32'((base + i) % AMOD));
                chk($sformatf("%s.wdat%0d", tag, i), 32'(wq_dat[i]), 32'(exp_w[i]));
                chk($sformatf("%s.wlst%0d", tag, i), 32'(wq_lst[i]), 32'(i == len));
            end
        end else begin
            chk({tag, ".rbeats"}, 32'(aq_add.size()), 32'(len + 1));
            chk({tag, ".sbeats"}, 32'(sq_dat.size()), 32'(len + 1));
            for (int i = 0; i <= len && i < aq_add.size(); i++) begin
                chk($sformatf("%s.radd%0d", tag, i), 32'(aq_add[i]), 32'((base + i) % AMOD));
                chk($sformatf("%s.rlst%0d", tag, i), 32'(aq_lst[i]), 32'(i == len));
            end
            for (int i = 0; i <= len && i < sq_dat.size(); i++) begin
                chk($sformatf("%s.sdat%0d", tag, i), 32'(sq_dat[i]),
                    32'(bank_mem[(base + i) % AMOD]));
                chk($sformatf("%s.slst%0d", tag, i), 32'(sq_lst[i]), 32'(i == len));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int d1, d2;
        bit ok;
        for (int i = 0; i < AMOD; i++) bank_mem[i] = 8'($urandom_range(0, 255));

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst.is_idle", 32'(is_idle), 32'd1);
        chk("rst.cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("rst.wtoe_rdy", 32'(wtoe_rdy), 32'd1);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.outs", 32'({src_rdy, etow_dat_vld, etow_add_vld, snk_vld, snk_lst,
                             etow_dat_lst, etow_add_lst}), 32'd0);
        tick();

        // Write, base 0x010, LEN 3
        clr_logs();
        fill_src(4);
        issue(1'b0, 'h010, 3);
        wait_idle("wr1");
        check_xfer(1'b0, 'h010, 3, "wr1");
        if (wq_cyc.size() == 4) begin
            chk("wr1.first_lat", 32'(wq_cyc[0] - cmd_acc_cyc), 32'd1);
            chk("wr1.idle_lat", 32'(idle_cyc - wq_cyc[3]), 32'd1);
        end

        // Read with address wrap, base 0x1FFE, LEN 5
        clr_logs();
        issue(1'b1, 'h1FFE, 5);
        wait_idle("rd1");
        check_xfer(1'b1, 'h1FFE, 5, "rd1");
        if (aq_cyc.size() > 0 && sq_cyc.size() == 6) begin
            chk("rd1.first_lat", 32'(aq_cyc[0] - cmd_acc_cyc), 32'd1);
            chk("rd1.ret_lat", 32'(sq_cyc[0] - aq_cyc[0]), 32'd2);
            chk("rd1.idle_lat", 32'(idle_cyc - sq_cyc[5]), 32'd1);
        end
        chk("rd1.err", 32'(err), 32'd0);

        // Credit limit with stalled sink
        clr_logs();
        snk_hold = 1'b1;
        tick();
        issue(1'b1, 'h0100, 9);
        repeat (20) tick();
        chk("credit.issued", 32'(aq_add.size()), 32'd4);
        @(negedge clk);
        chk("credit.add_vld", 32'(etow_add_vld), 32'd0);
        tick();
        snk_hold = 1'b0;
        wait_idle("credit");
        check_xfer(1'b1, 'h0100, 9, "credit");

        // LEN 0 read
        clr_logs();
        issue(1'b1, 'h0ABC, 0);
        wait_idle("rd0");
        check_xfer(1'b1, 'h0ABC, 0, "rd0");

        // LEN 0 write with CMD_VLD held: not re-accepted until back in IDLE
        clr_logs();
        c0 = cmd_acc_cnt;
        cmd_vld = 1'b1;
        cmd_mode = 1'b0;
        cmd_base = 13'h0AB;
        cmd_len = 13'd0;
        repeat (5) tick();
        chk("hold.accepts1", 32'(cmd_acc_cnt - c0), 32'd1);
        @(negedge clk);
        chk("hold.busy", 32'(is_idle), 32'd0);
        d1 = int'($urandom_range(0, 255));
        d2 = int'($urandom_range(0, 255));
        src_q.push_back(d1);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            ok = (cmd_acc_cnt - c0) >= 2;
        end
        cmd_vld = 1'b0;
        chk("hold.accepts2", 32'(cmd_acc_cnt - c0), 32'd2);
        src_q.push_back(d2);
        wait_idle("hold");
        chk("hold.beats", 32'(wq_add.size()), 32'd2);
        if (wq_add.size() == 2) begin
            chk("hold.add0", 32'(wq_add[0]), 32'h0AB);
            chk("hold.dat0", 32'(wq_dat[0]), 32'(d1));
            chk("hold.lst0", 32'(wq_lst[0]), 32'd1);
            chk("hold.add1", 32'(wq_add[1]), 32'h0AB);
            chk("hold.dat1", 32'(wq_dat[1]), 32'(d2));
            chk("hold.lst1", 32'(wq_lst[1]), 32'd1);
        end

        // Reset during the 3rd sink beat of a read
        clr_logs();
        issue(1'b1, 'h0200, 7);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = sq_dat.size() >= 2;
        end
        chk("rstmid.reached", 32'(ok), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid.is_idle", 32'(is_idle), 32'd1);
        chk("rstmid.snk_vld", 32'(snk_vld), 32'd0);
        chk("rstmid.add_vld", 32'(etow_add_vld), 32'd0);
        tick();
        repeat (3) tick();
        @(negedge clk);
        chk("rstmid.snk_vld_later", 32'(snk_vld), 32'd0);
        chk("rstmid.err", 32'(err), 32'd0);
        tick();
        clr_logs();
        issue(1'b1, 'h0300, 4);
        wait_idle("rstmid.after");
        check_xfer(1'b1, 'h0300, 4, "rstmid.after");

        // Stray return data in IDLE sets ERR until the next command accept
        inj_dat = 8'($urandom_range(0, 255));
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("inj.err_set", 32'(err), 32'd1);
        repeat (4) tick();
        @(negedge clk);
        chk("inj.err_held", 32'(err), 32'd1);
        tick();
        clr_logs();
        fill_src(1);
        issue(1'b0, 'h1FFF, 0);
        @(negedge clk);
        chk("inj.err_clr", 32'(err), 32'd0);
        tick();
        wait_idle("inj.wr");
        check_xfer(1'b0, 'h1FFF, 0, "inj.wr");

        // Randomized transfers with throttled source, bank and sink
        rnd = 1'b1;
        for (int t = 0; t < 10; t++) begin
            bit m;
            int b, l;
            m = 1'($urandom_range(0, 1));
            b = int'($urandom_range(0, AMOD - 1));
            l = int'($urandom_range(0, 12));
            clr_logs();
            if (m == 1'b0) fill_src(l + 1);
            issue(m, b, l);
            wait_idle($sformatf("rnd%0d", t));
            check_xfer(m, b, l, $sformatf("rnd%0d", t));
        end
        rnd = 1'b0;
        tick();
        @(negedge clk);
        chk("final.err", 32'(err), 32'd0);
        chk("final.idle", 32'(is_idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
